mipi_frame_deframer: RTL and testbench
======================================

# mipi_frame_deframer

Parametrised successor to the MIPI RX packet decoder. Accepts raw words from the MIPI CSI RX pixel interface and finds the SOF marker at any byte offset. It parses the metadata word and buffers payload speculatively, committing a frame only after a valid EOF, so that bad frames are discarded whole. Committed frames drain as a byte stream with valid/ready backpressure and frame tagging toward the UART or host-side consumers.

## Interface
- LANE_BYTES, 6: bytes per input word, legal 5..8; W = 8*LANE_BYTES.
- ADDR_WIDTH, 10: payload buffer depth = 2**ADDR_WIDTH words.
- SOF, 48'hEA_FF_99_DE_AD_FF: start marker, W bits.
- EOF, 48'hEA_FF_99_DE_AD_AA: end marker, W bits.

Ports:
- rx_pixel_clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  W  raw word; wire byte i = in_data[8i+7:8i], byte 0 first in time.
- in_valid  in  1  word qualifier; no backpressure on input.
- out_data  out  8  payload byte.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts byte.
- out_last  out  1  final byte of frame.
- out_app_id  out  8  app_id of frame being drained.
- frame_ok  out  1  one-cycle pulse, frame committed.
- frame_err  out  1  one-cycle pulse, frame aborted.
- err_code  out  2  1 EOF mismatch, 2 buffer overflow, 3 bad last_bytes; held until next frame_err.
- frames_ok_cnt  out  16  committed frames, wraps.

## Operation
- Marker byte i is SOF[8*(LANE_BYTES-1-i)+:8], most-significant byte first on the wire. The same rule applies to EOF.
- prev holds the last valid word; prev_vld is cleared by reset. Only cycles with in_valid=1 advance anything.
- Aligned word at offset o: bytes o..L-1 of prev followed by bytes 0..o-1 of cur.
- HUNT: when in_valid and prev_vld, test o = 0..L-1. The lowest matching offset wins. Lock o and go to META.
- META: parse the next aligned word.
  - byte0 = app_id.
  - bytes1..3 = len in words, MSB first.
  - byte4 = last_bytes.
  - last_bytes of 0 or >L gives err 3 and returns to HUNT.
  - len=0 goes to EOFCHK; otherwise go to PAYLOAD.
- PAYLOAD: write each aligned word to the buffer with {app_id, nbytes, last}.
  - nbytes = L, except the final word, which uses last_bytes.
  - After len words, go to EOFCHK.
- EOFCHK: compare the aligned word with EOF.
  - Match: wr_commit <= wr_ptr, pulse frame_ok, increment frames_ok_cnt. len=0 commits nothing but still pulses.
  - Mismatch: wr_ptr <= wr_commit, err 1.
  - Both cases return to HUNT.
- Overflow: a payload write while full aborts the frame, rolls back wr_ptr to wr_commit, sets err 2, and returns to HUNT. Full is judged against speculative wr_ptr versus rd_ptr.
- An SOF pattern inside a frame is data; there is no mid-frame resync.
- Drain: the reader sees only words with rd_ptr != wr_commit. It serialises bytes 0..nbytes-1 of each word in wire order.
  - out_last = 1 on the last byte of a word flagged last.
  - out_app_id comes from the word's entry.
- Handshake: a transfer occurs when out_valid & out_ready. out_data, out_last and out_app_id hold stable while out_valid & !out_ready. out_valid never drops without a transfer.

## Timing
- Reset: all outputs 0, err_code 0, counters 0, pointers 0, state HUNT, prev_vld 0. Reset mid-frame discards committed and uncommitted data.
- Store-and-forward: the earliest out_valid is 1 cycle after the clock edge accepting the EOF word.
- Drain throughput is 1 byte/cycle with out_ready held high, with no bubbles between words or frames.
- Simultaneous commit and drain are legal. The reader's empty check uses wr_commit registered before the edge.
- Pointers are ADDR_WIDTH+1 bits with a wrap bit. Buffer wrap-around is transparent.
- frame_ok and frame_err are never asserted in the same cycle.
- len is 24-bit; frames longer than the depth always end with overflow (err 2).

## Test plan
- Aligned frame, o=0: SOF, meta {0x05, len=2, last=3}, two words, EOF -> frame_ok.
  - Required output: 9 bytes in wire order, out_last on byte 9, out_app_id=0x05, frames_ok_cnt=1.
- Misaligned by 2 bytes with in_valid gaps -> identical byte stream and flags as the aligned case.
- Corrupted EOF byte -> frame_err, err_code=1, no out_valid. A following good frame drains normally.
- ADDR_WIDTH=4, len=20 -> err_code=2, buffer empty. Any earlier committed frame still drains intact.
- out_ready toggling 1/0 every other cycle across two back-to-back frames -> no byte lost or duplicated, data stable during stalls.
- Assert rst mid-PAYLOAD -> outputs 0 next cycle. A subsequent frame decodes correctly.

Source files
------------

// File: rtl/mipi_frame_deframer.sv
// CSI RX word deframer: locks onto SOF at any byte offset, buffers payload speculatively
// and commits a frame only on a matching EOF, then drains committed bytes with valid/ready.
module mipi_frame_deframer #(
    parameter int LANE_BYTES = 6,
    parameter int ADDR_WIDTH = 10,
    parameter logic [8*LANE_BYTES-1:0] SOF = 48'hEA_FF_99_DE_AD_FF,
    parameter logic [8*LANE_BYTES-1:0] EOF = 48'hEA_FF_99_DE_AD_AA
) (
    input  logic                    rx_pixel_clk,
    input  logic                    rst,
    input  logic [8*LANE_BYTES-1:0] in_data,
    input  logic                    in_valid,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [7:0]              out_app_id,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic [15:0]             frames_ok_cnt
);

    localparam int W       = 8 * LANE_BYTES;
    localparam int ENTRY_W = W + 4 + 1 + 8;

    typedef enum logic [1:0] {HUNT, META, PAYLOAD, EOFCHK} state_t;

    // Markers are given most-significant byte first; wire byte 0 is the first in time.
    function automatic logic [W-1:0] wire_order(input logic [W-1:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            r[8*i +: 8] = m[8*(LANE_BYTES-1-i) +: 8];
        end
        return r;
    endfunction

    // Bytes o..L-1 of the previous word followed by bytes 0..o-1 of the current one.
    function automatic logic [W-1:0] align(input logic [W-1:0] p, input logic [W-1:0] c,
                                           input logic [2:0] o);
        logic [2*W-1:0] cat;
        cat = {c, p} >> (8 * o);
        return cat[W-1:0];
    endfunction

    state_t                state;
    logic [W-1:0]          prev;
    logic                  prev_vld;
    logic [2:0]            off;
    logic [7:0]            app_id;
    logic [23:0]           len_left;
    logic [3:0]            last_bytes;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   wr_commit;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [2:0]            byte_idx;
    logic [ENTRY_W-1:0]    mem [0:(1<<ADDR_WIDTH)-1];

    logic [W-1:0]          sof_wire;
    logic [W-1:0]          eof_wire;
    logic [W-1:0]          aligned;
    logic                  hit;
    logic [2:0]            hit_off;
    logic [7:0]            meta_lb;
    logic [23:0]           meta_len;
    logic                  full;
    logic                  wr_en;
    logic [3:0]            wr_nb;
    logic                  wr_last;

    assign sof_wire = wire_order(SOF);
    assign eof_wire = wire_order(EOF);
    assign aligned  = align(prev, in_data, off);
    assign meta_lb  = aligned[39:32];
    assign meta_len = {aligned[15:8], aligned[23:16], aligned[31:24]};
    assign full     = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign wr_en    = in_valid && (state == PAYLOAD) && !full;
    assign wr_last  = (len_left == 24'd1);
    assign wr_nb    = wr_last ? last_bytes : 4'(LANE_BYTES);

    // Descending scan so the lowest matching offset is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_off = '0;
        for (int o = LANE_BYTES - 1; o >= 0; o--) begin
            if (align(prev, in_data, 3'(o)) == sof_wire) begin
                hit     = 1'b1;
                hit_off = 3'(o);
            end
        end
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (in_valid) begin
            prev <= in_data;
        end
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {app_id, wr_nb, wr_last, aligned};
        end
    end

    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            prev_vld      <= 1'b0;
            off           <= '0;
            app_id        <= '0;
            len_left      <= '0;
            last_bytes    <= '0;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            frames_ok_cnt <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (in_valid) begin
                prev_vld <= 1'b1;
                case (state)
                    HUNT: begin
                        if (prev_vld && hit) begin
                            off   <= hit_off;
                            state <= META;
                        end
                    end
                    META: begin
                        app_id     <= aligned[7:0];
                        len_left   <= meta_len;
                        last_bytes <= meta_lb[3:0];
                        if (meta_lb == 8'd0 || meta_lb > 8'(LANE_BYTES)) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd3;
                            state     <= HUNT;
                        end else if (meta_len == 24'd0) begin
                            state <= EOFCHK;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (full) begin
                            wr_ptr    <= wr_commit;
                            frame_err <= 1'b1;
                            err_code  <= 2'd2;
                            state     <= HUNT;
                        end else begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            len_left <= len_left - 24'd1;
                            if (wr_last) begin
                                state <= EOFCHK;
                            end
                        end
                    end
                    EOFCHK: begin
                        if (aligned == eof_wire) begin
                            wr_commit     <= wr_ptr;
                            frame_ok      <= 1'b1;
                            frames_ok_cnt <= frames_ok_cnt + 16'd1;
                        end else begin
                            wr_ptr    <= wr_commit;
                            frame_err <= 1'b1;
                            err_code  <= 2'd1;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    logic [ENTRY_W-1:0] rd_entry;
    logic [W-1:0]       rd_word;
    logic               rd_last;
    logic [3:0]         rd_nb;
    logic [7:0]         rd_app;
    logic               rd_avail;
    logic               rd_final;
    logic               out_load;

    assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_word  = rd_entry[W-1:0];
    assign rd_last  = rd_entry[W];
    assign rd_nb    = rd_entry[W+4:W+1];
    assign rd_app   = rd_entry[W+12:W+5];
    assign rd_avail = (rd_ptr != wr_commit);
    assign rd_final = ({1'b0, byte_idx} == rd_nb - 4'd1);
    assign out_load = !out_valid || out_ready;

    // Output register refills on the same edge a byte leaves, so the stream has no bubbles.
    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            byte_idx   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_app_id <= '0;
        end else if (out_load) begin
            out_valid <= rd_avail;
            if (rd_avail) begin
                out_data   <= rd_word[8*byte_idx +: 8];
                out_last   <= rd_last && rd_final;
                out_app_id <= rd_app;
                if (rd_final) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mipi_frame_deframer.sv
// Bench for mipi_frame_deframer: table of frames plus hand-written overflow, stall and reset sequences.
module tb_mipi_frame_deframer;

    localparam int L  = 6;
    localparam int W  = 8 * L;
    localparam int AW = 4;
    localparam logic [47:0] SOF_M = 48'hEA_FF_99_DE_AD_FF;
    localparam logic [47:0] EOF_M = 48'hEA_FF_99_DE_AD_AA;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [7:0]   out_app_id;
    logic         frame_ok;
    logic         frame_err;
    logic [1:0]   err_code;
    logic [15:0]  frames_ok_cnt;

    mipi_frame_deframer #(.LANE_BYTES(L), .ADDR_WIDTH(AW)) dut (
        .rx_pixel_clk (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_app_id   (out_app_id),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .frames_ok_cnt(frames_ok_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] app;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  app;
        logic [23:0] len;
        logic [7:0]  lb;
        int          off;
        bit          gaps;
        bit          bad_eof;
        int          exp_ok;
        int          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] bs[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         ok_pulses = 0;
    int         err_pulses = 0;
    int         model_cnt = 0;
    int         rdy_mode = 1;
    bit         stall_q = 1'b0;
    logic [16:0] hold_q;
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // out_ready: 0 = held low, 1 = held high, 2 = alternating each cycle
    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 2) out_ready = ~out_ready;
        else out_ready = (rdy_mode == 1);
    end

    // Scoreboard, stall-stability and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_hold", 32'({out_valid, out_last, out_app_id, out_data}), 32'({1'b1, hold_q}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h app %0h, expected none", out_data, out_app_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("byte", 32'({out_last, out_app_id, out_data}), 32'(e));
                end
            end
            stall_q = out_valid && !out_ready;
            hold_q  = {out_last, out_app_id, out_data};
            if (frame_ok) ok_pulses++;
            if (frame_err) err_pulses++;
            if (frame_ok || frame_err) chk("ok_err_exclusive", 32'(frame_ok && frame_err), 32'd0);
        end
    end

    task automatic build_frame(input logic [7:0] app, input logic [23:0] len, input logic [7:0] lb,
                               input int off, input bit bad_eof, input bit push_exp);
        logic [47:0] m;
        bs.delete();
        repeat (off) bs.push_back(8'h11);
        m = SOF_M;
        for (int i = 0; i < L; i++) bs.push_back(m[8*(L-1-i) +: 8]);
        bs.push_back(app);
        bs.push_back(len[23:16]);
        bs.push_back(len[15:8]);
        bs.push_back(len[7:0]);
        bs.push_back(lb);
        repeat (L - 5) bs.push_back(8'h00);
        for (int w = 0; w < int'(len); w++) begin
            for (int i = 0; i < L; i++) begin
                logic [7:0] b;
                int nb;
                b  = app ^ 8'((w * L + i) * 7 + 3);
                nb = (w == int'(len) - 1) ? int'(lb) : L;
                bs.push_back(b);
                if (push_exp && i < nb) sb.push_back({(w == int'(len) - 1) && (i == nb - 1), app, b});
            end
        end
        m = EOF_M;
        for (int i = 0; i < L; i++) begin
            logic [7:0] b;
            b = m[8*(L-1-i) +: 8];
            if (bad_eof && i == L - 1) b = b ^ 8'h01;
            bs.push_back(b);
        end
        repeat (2 * L) bs.push_back(8'h00);
    endtask

    task automatic send_stream(input int max_words, input bit gaps);
        int nw;
        nw = (bs.size() + L - 1) / L;
        if (max_words < nw) nw = max_words;
        for (int k = 0; k < nw; k++) begin
            logic [W-1:0] w;
            w = '0;
            for (int i = 0; i < L; i++) if (k * L + i < bs.size()) w[8*i +: 8] = bs[k*L+i];
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_data  = w;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
        chk({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int ok0, err0;
        ok0  = ok_pulses;
        err0 = err_pulses;
        build_frame(v.app, v.len, v.lb, v.off, v.bad_eof, v.exp_ok != 0);
        if (v.exp_ok != 0) model_cnt++;
        send_stream(1000, v.gaps);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_ok_pulse"}, 32'(ok_pulses - ok0), 32'(v.exp_ok));
        chk({name, "_err_pulse"}, 32'(err_pulses - err0), 32'(v.exp_err));
        if (v.exp_ok == 0) begin
            chk({name, "_err_code"}, 32'(err_code), 32'(v.exp_code));
            chk({name, "_no_output"}, 32'(out_valid), 32'd0);
        end
        chk({name, "_ok_cnt"}, 32'(frames_ok_cnt), 32'(model_cnt));
        wait_drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0, err0;
        vec_t v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_app", 32'(out_app_id), 32'd0);
        chk("rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_ok_cnt", 32'(frames_ok_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //            app    len  lb    off gaps bad ok err code
        vecs[0] = '{8'h05, 24'd2, 8'd3, 0, 1'b0, 1'b0, 1, 0, 2'd0};
        vecs[1] = '{8'h05, 24'd2, 8'd3, 2, 1'b1, 1'b0, 1, 0, 2'd0};
        vecs[2] = '{8'h07, 24'd1, 8'd4, 1, 1'b0, 1'b1, 0, 1, 2'd1};
        vecs[3] = '{8'h33, 24'd1, 8'd6, 5, 1'b0, 1'b0, 1, 0, 2'd0};
        vecs[4] = '{8'h44, 24'd1, 8'd0, 3, 1'b0, 1'b0, 0, 1, 2'd3};
        vecs[5] = '{8'h45, 24'd1, 8'd7, 0, 1'b1, 1'b0, 0, 1, 2'd3};
        vecs[6] = '{8'h46, 24'd0, 8'd2, 4, 1'b1, 1'b0, 1, 0, 2'd0};
        vecs[7] = '{8'h5A, 24'd3, 8'd5, 1, 1'b0, 1'b0, 1, 0, 2'd0};
        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Overflow with a committed frame parked in the buffer.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        ok0  = ok_pulses;
        err0 = err_pulses;
        build_frame(8'h61, 24'd2, 8'd6, 0, 1'b0, 1'b1);
        model_cnt++;
        send_stream(1000, 1'b0);
        build_frame(8'h62, 24'd20, 8'd6, 3, 1'b0, 1'b0);
        send_stream(1000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_ok_pulse", 32'(ok_pulses - ok0), 32'd1);
        chk("ovf_err_pulse", 32'(err_pulses - err0), 32'd1);
        chk("ovf_err_code", 32'(err_code), 32'd2);
        chk("ovf_pending_valid", 32'(out_valid), 32'd1);
        chk("ovf_pending_app", 32'(out_app_id), 32'h61);
        rdy_mode = 1;
        wait_drain("ovf");
        v = '{8'h63, 24'd2, 8'd1, 2, 1'b0, 1'b0, 1, 0, 2'd0};
        run_vec("post_ovf", v);
        chk("err_code_held", 32'(err_code), 32'd2);

        // Two back-to-back frames drained with out_ready alternating.
        rdy_mode = 2;
        ok0 = ok_pulses;
        build_frame(8'h71, 24'd2, 8'd5, 1, 1'b0, 1'b1);
        send_stream(1000, 1'b0);
        build_frame(8'h72, 24'd3, 8'd2, 4, 1'b0, 1'b1);
        send_stream(1000, 1'b0);
        model_cnt += 2;
        repeat (3) @(posedge clk);
        #1;
        chk("toggle_ok_pulses", 32'(ok_pulses - ok0), 32'd2);
        wait_drain("toggle");
        chk("toggle_ok_cnt", 32'(frames_ok_cnt), 32'(model_cnt));

        // Reset in the middle of a payload, with a committed frame still undrained.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        build_frame(8'h81, 24'd1, 8'd4, 0, 1'b0, 1'b1);
        send_stream(1000, 1'b0);
        build_frame(8'h82, 24'd5, 8'd6, 0, 1'b0, 1'b0);
        send_stream(4, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        model_cnt = 0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'({out_last, out_app_id, out_data}), 32'd0);
        chk("mid_rst_err_code", 32'(err_code), 32'd0);
        chk("mid_rst_ok_cnt", 32'(frames_ok_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        v = '{8'h91, 24'd2, 8'd3, 3, 1'b1, 1'b0, 1, 0, 2'd0};
        run_vec("post_rst", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
